count_sweep_ctrl: RTL and testbench
===================================

COUNT_SWEEP_CTRL -- requirements
Module: count_sweep_ctrl

Interface
REQ-001 Parameter N, default 8, counter and limit width in bits.
REQ-002 Parameter SW, default 4, sweep-count width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a sweep run; sampled in IDLE only.
REQ-006 abort  input  1  terminate a run in progress.
REQ-007 hold  input  1  freeze the count while running.
REQ-008 lo_lim  input  N  lower ramp limit, unsigned.
REQ-009 hi_lim  input  N  upper ramp limit, unsigned.
REQ-010 sweeps  input  SW  number of lo->hi->lo sweeps.
REQ-011 UP_DOWN  output  1  current direction; 1 = incrementing, 0 = decrementing or idle.
REQ-012 count  output  N  counter value, registered.
REQ-013 busy  output  1  high in UP and DOWN states.
REQ-014 done  output  1  one-cycle pulse on normal completion.
REQ-015 err  output  1  one-cycle pulse on a rejected start.

Function
REQ-016 The FSM SHALL have exactly these states: IDLE, UP, DOWN, DONE.
REQ-017 IDLE behaviour:
- count holds; UP_DOWN=0.
- start=1 with lo_lim<hi_lim and sweeps!=0: latch lo_lim, hi_lim and sweeps into internal registers; count<=lo_lim; go to UP.
REQ-018 IDLE, start=1 with lo_lim>=hi_lim or sweeps==0: err=1 the next cycle; remain in IDLE; count unchanged.
REQ-019 UP, no hold/abort: count<=count+1 per cycle; on the edge where count becomes latched hi, go to DOWN.
REQ-020 DOWN, no hold/abort: count<=count-1 per cycle; on the edge where count becomes latched lo, decrement remaining sweeps; go to DONE if remaining was 1, else go to UP.
REQ-021 One sweep SHALL take exactly 2*(hi-lo) cycles.
REQ-022 Limits and count never leave [lo,hi]; no wrap-around is possible, including lo=0, hi=2^N-1.
REQ-023 hold=1 in UP or DOWN: count, state and remaining sweeps unchanged; UP_DOWN keeps its value.
REQ-024 abort=1 in UP or DOWN: go to IDLE next cycle; count holds its current value; done not asserted.
REQ-025 Priority SHALL be abort > hold > limit transition.
REQ-026 DONE: done=1 for exactly one cycle; count holds at latched lo; go to IDLE next cycle.
REQ-027 start SHALL be ignored in UP, DOWN and DONE; limit/sweeps input changes while running have no effect.
REQ-028 Latency: count=lo_lim on the first edge after start is sampled; busy rises on the same edge.

Reset
REQ-029 reset=1 SHALL on the next edge force: state=IDLE, count=0, UP_DOWN=0, busy=0, done=0, err=0, latched limits=0, remaining sweeps=0.
REQ-030 reset SHALL override start, abort and hold in any state, including mid-sweep; no done pulse results.

Structure
REQ-031 Package count_ctrl_pkg SHALL hold the state enum typedef and default N/SW constants.
REQ-032 The counter SHALL be a sub-module updown_count_core (clk, reset, en, load, load_val, UP_DOWN, count); the FSM drives en/load/UP_DOWN only.

Verification
REQ-033 lo=3, hi=6, sweeps=2, start -> count 3,4,5,6,5,4,3,4,5,6,5,4,3 on successive cycles; done pulse one cycle later; busy low afterwards.
REQ-034 lo=5, hi=5, start -> err=1 for one cycle; state IDLE; count unchanged. sweeps=0 -> same result.
REQ-035 lo=0, hi=255, sweeps=1 -> count reaches 255 then returns to 0 with no wrap; done after 510 counting cycles.
REQ-036 lo=3, hi=6, sweeps=1; hold high for 3 cycles at count=5 while UP -> count stays 5 for 3 cycles; sequence then resumes at 6.
REQ-037 abort at count=4 while DOWN -> IDLE next cycle; count=4; busy=0; no done pulse. Asserting hold together with abort gives the same result.
REQ-038 reset asserted at count=5 mid-sweep -> next edge count=0, busy=0; a new start afterwards runs normally.

Source files
------------

// File: rtl/count_ctrl_pkg.sv
// Shared types and default widths for the sweep counter controller.
package count_ctrl_pkg;

  localparam int N_DEF  = 8;
  localparam int SW_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/updown_count_core.sv
// Loadable up/down counter; load wins over enable, no wrap protection
// here because the controller never steps past its latched limits.
module updown_count_core
  import count_ctrl_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         UP_DOWN,
  output logic [N-1:0] count
);

  logic [N-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en) begin
      r_count <= UP_DOWN ? r_count + N'(1) : r_count - N'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/count_sweep_ctrl.sv
// Sweep controller: ramps count lo->hi->lo a latched number of times.
//   state | meaning
//   IDLE  | waiting for a valid start; count holds
//   UP    | incrementing toward latched hi
//   DOWN  | decrementing toward latched lo
//   DONE  | final sweep finished; done pulses on the following cycle
module count_sweep_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int SW = SW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          hold,
  input  logic [N-1:0]  lo_lim,
  input  logic [N-1:0]  hi_lim,
  input  logic [SW-1:0] sweeps,
  output logic          UP_DOWN,
  output logic [N-1:0]  count,
  output logic          busy,
  output logic          done,
  output logic          err
);

  state_t        r_state;
  logic [N-1:0]  r_lo;
  logic [N-1:0]  r_hi;
  logic [SW-1:0] r_rem;
  logic          r_up_down;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  logic [N-1:0]  w_count;
  logic          w_start_ok;
  logic          w_load;
  logic          w_en;
  logic          w_at_hi;
  logic          w_at_lo;

  assign w_start_ok = (lo_lim < hi_lim) && (sweeps != '0);
  assign w_load     = (r_state == IDLE) && start && w_start_ok;
  assign w_en       = ((r_state == UP) || (r_state == DOWN)) && !abort && !hold;
  // Turn around one step early so count lands exactly on the limit and never wraps.
  assign w_at_hi    = (w_count == r_hi - N'(1));
  assign w_at_lo    = (w_count == r_lo + N'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_lo      <= '0;
      r_hi      <= '0;
      r_rem     <= '0;
      r_up_down <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_up_down <= 1'b0;
          r_busy    <= 1'b0;
          if (start) begin
            if (w_start_ok) begin
              r_lo      <= lo_lim;
              r_hi      <= hi_lim;
              r_rem     <= sweeps;
              r_state   <= UP;
              r_up_down <= 1'b1;
              r_busy    <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        UP: begin
          if (abort) begin
            r_state   <= IDLE;
            r_up_down <= 1'b0;
            r_busy    <= 1'b0;
          end else if (!hold && w_at_hi) begin
            r_state   <= DOWN;
            r_up_down <= 1'b0;
          end
        end
        DOWN: begin
          if (abort) begin
            r_state   <= IDLE;
            r_up_down <= 1'b0;
            r_busy    <= 1'b0;
          end else if (!hold && w_at_lo) begin
            r_rem <= r_rem - SW'(1);
            if (r_rem == SW'(1)) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
            end else begin
              r_state   <= UP;
              r_up_down <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b1;
        end
        default: begin
          r_state   <= IDLE;
          r_up_down <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  updown_count_core #(.N(N)) u_core (
    .clk      (clk),
    .reset    (reset),
    .en       (w_en),
    .load     (w_load),
    .load_val (lo_lim),
    .UP_DOWN  (r_up_down),
    .count    (w_count)
  );

  assign UP_DOWN = r_up_down;
  assign count   = w_count;
  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;

endmodule

// File: tb/tb_count_sweep_ctrl.sv
// Directed bench for count_sweep_ctrl with hand-computed expectations.
module tb_count_sweep_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic       hold;
  logic [7:0] lo_lim;
  logic [7:0] hi_lim;
  logic [3:0] sweeps;
  logic       UP_DOWN;
  logic [7:0] count;
  logic       busy;
  logic       done;
  logic       err;

  int n_chk;
  int n_err;

  count_sweep_ctrl #(.N(8), .SW(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .hold    (hold),
    .lo_lim  (lo_lim),
    .hi_lim  (hi_lim),
    .sweeps  (sweeps),
    .UP_DOWN (UP_DOWN),
    .count   (count),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int lo, input int hi, input int sw);
    lo_lim = 8'(lo);
    hi_lim = 8'(hi);
    sweeps = 4'(sw);
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  int seq2[13] = '{3, 4, 5, 6, 5, 4, 3, 4, 5, 6, 5, 4, 3};
  int ud2[13]  = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0};
  int seq1[7]  = '{3, 4, 5, 6, 5, 4, 3};

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; hold = 1'b0;
    lo_lim = '0; hi_lim = '0; sweeps = '0;
    tick();
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ud", UP_DOWN, 0);
    reset = 1'b0;
    tick();

    // Two sweeps 3..6; inputs scrambled mid-run must be ignored.
    go(3, 6, 2);
    check("s2_count0", count, seq2[0]);
    check("s2_busy0", busy, 1);
    check("s2_ud0", UP_DOWN, ud2[0]);
    lo_lim = 8'd0; hi_lim = 8'd9; sweeps = 4'd7;
    for (int i = 1; i < 13; i++) begin
      tick();
      check($sformatf("s2_count%0d", i), count, seq2[i]);
      check($sformatf("s2_ud%0d", i), UP_DOWN, ud2[i]);
      check($sformatf("s2_done%0d", i), done, 0);
      check($sformatf("s2_busy%0d", i), busy, (i == 12) ? 0 : 1);
    end
    tick();
    check("s2_done_pulse", done, 1);
    check("s2_busy_end", busy, 0);
    check("s2_count_end", count, 3);
    tick();
    check("s2_done_low", done, 0);

    // Rejected starts: equal limits, zero sweeps, inverted limits.
    go(5, 5, 1);
    check("eq_err", err, 1);
    check("eq_busy", busy, 0);
    check("eq_count", count, 3);
    tick();
    check("eq_err_low", err, 0);
    go(3, 6, 0);
    check("sw0_err", err, 1);
    check("sw0_busy", busy, 0);
    check("sw0_count", count, 3);
    tick();
    check("sw0_err_low", err, 0);
    go(7, 6, 1);
    check("inv_err", err, 1);
    check("inv_count", count, 3);
    tick();

    // Full-range sweep, no wrap at either end.
    go(0, 255, 1);
    check("full_count0", count, 0);
    for (int i = 1; i <= 510; i++) begin
      tick();
      check($sformatf("full_count%0d", i), count, (i <= 255) ? i : 510 - i);
      check($sformatf("full_done%0d", i), done, 0);
    end
    check("full_busy_end", busy, 0);
    tick();
    check("full_done_pulse", done, 1);
    tick();

    // Hold for three cycles at 5 while rising; stray start is ignored.
    go(3, 6, 1);
    tick();
    tick();
    check("hold_pre", count, 5);
    hold = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold_count%0d", i), count, 5);
      check($sformatf("hold_ud%0d", i), UP_DOWN, 1);
      check($sformatf("hold_busy%0d", i), busy, 1);
    end
    hold = 1'b0;
    start = 1'b0;
    for (int i = 3; i < 7; i++) begin
      tick();
      check($sformatf("hold_seq%0d", i), count, seq1[i]);
    end
    tick();
    check("hold_done", done, 1);
    tick();

    // Abort at 4 while falling, alone and together with hold.
    for (int k = 0; k < 2; k++) begin
      go(3, 6, 1);
      for (int i = 1; i < 6; i++) tick();
      check($sformatf("ab%0d_pre", k), count, 4);
      check($sformatf("ab%0d_pre_ud", k), UP_DOWN, 0);
      abort = 1'b1;
      hold  = (k == 1);
      tick();
      abort = 1'b0;
      hold  = 1'b0;
      check($sformatf("ab%0d_count", k), count, 4);
      check($sformatf("ab%0d_busy", k), busy, 0);
      check($sformatf("ab%0d_done", k), done, 0);
      tick();
      tick();
      check($sformatf("ab%0d_done_late", k), done, 0);
      check($sformatf("ab%0d_count_late", k), count, 4);
    end

    // Reset mid-sweep, then a fresh run 2..4.
    go(3, 6, 1);
    tick();
    tick();
    check("rs_pre", count, 5);
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("rs_count", count, 0);
    check("rs_busy", busy, 0);
    tick();
    check("rs_done", done, 0);
    check("rs_count_idle", count, 0);
    go(2, 4, 1);
    check("rs2_count0", count, 2);
    tick(); check("rs2_count1", count, 3);
    tick(); check("rs2_count2", count, 4);
    tick(); check("rs2_count3", count, 3);
    tick(); check("rs2_count4", count, 2);
    check("rs2_busy_end", busy, 0);
    tick(); check("rs2_done", done, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
